if_prefetch_queue: RTL

//  Parametrised instruction-fetch stage with a prefetch queue and a req/ack memory port.

---
 rtl/if_prefetch_queue.sv | 129 ++++++++++++
 1 files changed

// File: rtl/if_prefetch_queue.sv
// Instruction fetch stage: sequential prefetch into a DEPTH-entry queue, registered IF/ID output.
// Latency: an ack pushes at edge E, and that entry reaches PC/Instruction at edge E+1 at the earliest.
// Backpressure: freeze holds the output register; the queue fills and requests stop at DEPTH entries.
module if_prefetch_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [ADDR_W-1:0] PC_STEP  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         freeze,
    input  logic                         branch_taken,
    input  logic [ADDR_W-1:0]            branch_addr,
    output logic                         imem_req,
    output logic [ADDR_W-1:0]            imem_addr,
    input  logic                         imem_ack,
    input  logic [DATA_W-1:0]            imem_rdata,
    output logic [ADDR_W-1:0]            PC,
    output logic [DATA_W-1:0]            Instruction,
    output logic                         valid,
    output logic [$clog2(DEPTH+1)-1:0]   queue_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] ins;
    } entry_t;

    typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] hold_addr;
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count, count_nxt;
    logic              push, pop;
    entry_t            wr_entry;
    entry_t            mem [DEPTH];

    assign push        = (state == WAIT) && imem_ack && !branch_taken;
    assign pop         = !branch_taken && !freeze && (count != '0);
    assign imem_req    = (state == WAIT) || (state == DISCARD);
    // A discarded request keeps its original address on the bus until the memory acks it.
    assign imem_addr   = (state == DISCARD) ? hold_addr : fetch_pc;
    assign queue_count = count;
    assign wr_entry    = '{pc: fetch_pc + PC_STEP, ins: imem_rdata};

    always_comb begin
        count_nxt = count;
        if (branch_taken)
            count_nxt = '0;
        else
            count_nxt = count + CNT_W'(push) - CNT_W'(pop);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (count < FULL && !branch_taken)
                    state_nxt = WAIT;
            end
            WAIT: begin
                if (imem_ack)
                    state_nxt = (!branch_taken && count_nxt < FULL) ? WAIT : IDLE;
                else if (branch_taken)
                    state_nxt = DISCARD;
            end
            DISCARD: begin
                if (imem_ack)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            hold_addr   <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            PC          <= '0;
            Instruction <= '0;
            valid       <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            if (state == WAIT && state_nxt == DISCARD)
                hold_addr <= fetch_pc;
            if (branch_taken) begin
                fetch_pc    <= branch_addr;
                rd_ptr      <= '0;
                wr_ptr      <= '0;
                PC          <= '0;
                Instruction <= '0;
                valid       <= 1'b0;
            end else begin
                if (push) begin
                    fetch_pc <= fetch_pc + PC_STEP;
                    wr_ptr   <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr      <= rd_ptr + PTR_W'(1);
                    PC          <= mem[rd_ptr].pc;
                    Instruction <= mem[rd_ptr].ins;
                    valid       <= 1'b1;
                end else if (!freeze) begin
                    PC          <= '0;
                    Instruction <= '0;
                    valid       <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_entry;
    end

endmodule
